// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_mem_loader_pkg : shared FSM encoding and stream-format constants.
// Rev 1.0
// ---------------------------------------------------------------------------
package instr_mem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6,
      ST_CHK    = 3'd7
   } state_t;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam bit BIG_ENDIAN     = 1'b1;

   function automatic logic is_busy(input state_t s);
      return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_WRITE, ST_CHK};
   endfunction

   function automatic logic accepts_bytes(input state_t s);
      return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_word_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// loader_word_assembler : 8->32 shift register with byte counter.
// Rev 1.0
// ---------------------------------------------------------------------------
module loader_word_assembler
   import instr_mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_complete
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);

   logic [CNT_W-1:0] byte_cnt;
   logic [31:0]      shreg;
   logic [31:0]      shifted;

   generate
      if (BIG_ENDIAN) begin : g_big_endian
         assign shifted = {shreg[23:0], byte_in};
      end else begin : g_little_endian
         assign shifted = {byte_in, shreg[31:8]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg    <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         shreg    <= '0;
         byte_cnt <= '0;
      end else if (shift_en) begin
         shreg    <= shifted;
         byte_cnt <= byte_cnt + 1'b1;
      end
   end

   // word already includes the byte being accepted, so it is complete in the
   // same cycle word_complete fires.
   assign word          = shift_en ? shifted : shreg;
   assign word_complete = shift_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_mem_loader : streams a length-prefixed image into instruction BRAM
// and holds the CPU in reset until done. Option: LOADER_CHECKSUM_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold
);

   localparam int LEN_W = 8 * LEN_BYTES;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t END_ST = ST_CHK;
`else
   localparam state_t END_ST = ST_DONE;
`endif

   state_t           state;
   state_t           next_state;
   logic [7:0]       len_hi;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] new_len;
   logic [LEN_W-1:0] word_cnt;
   logic             xfer;
   logic             asm_clear;
   logic             asm_shift;
   logic [31:0]      asm_word;
   logic             asm_complete;

   assign xfer    = in_valid & in_ready;
   assign new_len = {len_hi, in_data};

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] cks;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cks <= '0;
      end else if (asm_clear) begin
         cks <= '0;
      end else if (xfer && state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA}) begin
         cks <= cks ^ in_data;
      end
   end
`endif

   loader_word_assembler u_asm (
      .clk           (clk),
      .rst           (rst),
      .clear         (asm_clear),
      .shift_en      (asm_shift),
      .byte_in       (in_data),
      .word          (asm_word),
      .word_complete (asm_complete)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      asm_clear  = 1'b0;
      asm_shift  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               next_state = ST_LEN_HI;
               asm_clear  = 1'b1;
            end
         end
         ST_LEN_HI: begin
            if (xfer) next_state = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (xfer) begin
               if (new_len == '0)                next_state = END_ST;
               else if (int'(new_len) > DEPTH)   next_state = ST_ERR;
               else                              next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            asm_shift = xfer;
            if (asm_complete) next_state = ST_WRITE;
         end
         ST_WRITE: begin
            if ((word_cnt + LEN_W'(1)) == len) next_state = END_ST;
            else                               next_state = ST_DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (xfer) next_state = (in_data == cks) ? ST_DONE : ST_ERR;
         end
`endif
         default: next_state = ST_IDLE;
      endcase
   end

   // Outputs are registered from next_state so they line up with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cpu_hold <= 1'b1;
         len_hi   <= '0;
         len      <= '0;
         word_cnt <= '0;
      end else begin
         in_ready <= accepts_bytes(next_state);
         busy     <= is_busy(next_state);
         done     <= (next_state == ST_DONE);
         err      <= (next_state == ST_ERR);
         cpu_hold <= (next_state != ST_DONE);
         mem_we   <= (next_state == ST_WRITE);
         if (next_state == ST_WRITE) begin
            mem_addr <= word_cnt[ADDR_W-1:0];
            mem_din  <= asm_word;
         end
         if (asm_clear)               word_cnt <= '0;
         else if (state == ST_WRITE)  word_cnt <= word_cnt + LEN_W'(1);
         if (state == ST_LEN_HI && xfer) len_hi <= in_data;
         if (state == ST_LEN_LO && xfer) len    <= new_len;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_mem_loader : directed + randomized bench with a stream-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              busy;
   logic              done;
   logic              err;
   logic              cpu_hold;

   int checks   = 0;
   int failures = 0;

   logic [ADDR_W+31:0] wq[$];
   logic [7:0]         stream[$];
   logic               prev_we = 1'b0;

   instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .cpu_hold (cpu_hold)
   );

   always #5 clk = ~clk;

   // Record every BRAM write; a write pulse must never last two cycles.
   always @(negedge clk) begin
      if (mem_we) begin
         wq.push_back({mem_addr, mem_din});
         checks++;
         assert (prev_we === 1'b0) else begin
            failures++;
            $error("FAIL we_single_cycle observed=%b expected=0", prev_we);
         end
      end
      prev_we = mem_we;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_mem_we"},   64'(mem_we),   64'd0);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_mem_din"},  64'(mem_din),  64'd0);
      chk({tag, "_busy"},     64'(busy),     64'd0);
      chk({tag, "_done"},     64'(done),     64'd0);
      chk({tag, "_err"},      64'(err),      64'd0);
      chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte until accepted; optional idle gaps and stray start pulses.
   task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke);
      int  guard;
      bit  rdy;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (poke && $urandom_range(0, 1) == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      guard    = 0;
      forever begin
         rdy = in_ready;
         @(negedge clk);
         if (rdy) break;
         guard++;
         if (guard > 100) begin
            chk("byte_accept_timeout", 64'(guard), 64'd0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk({tag, "_idle_timeout"}, 64'(busy), 64'd0);
   endtask

   // Close the stream: append the XOR checksum (optionally corrupted) when
   // the checksum option is built in and the length is legal.
   task automatic finish_stream(input bit bad);
`ifdef LOADER_CHECKSUM_EN
      int         n;
      logic [7:0] x;
      n = {stream[0], stream[1]};
      if (n <= DEPTH) begin
         x = 8'h00;
         for (int i = 0; i < 2 + 4 * n; i++) x ^= stream[i];
         stream.push_back(bad ? (x ^ 8'h01) : x);
      end
`else
      if (bad) stream.push_back(8'h00);
`endif
   endtask

   task automatic build_random(input int n);
      stream.delete();
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
      finish_stream(1'b0);
   endtask

   // Reference model: derive expected writes and outcome from the stream.
   task automatic run_load(input string tag, input bit gaps, input bit poke);
      int          n;
      int          nwr;
      int          consumed;
      bit          ok;
      logic [31:0] w;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0]  x;
`endif
      n        = {stream[0], stream[1]};
      ok       = (n <= DEPTH);
      nwr      = ok ? n : 0;
      consumed = ok ? 2 + 4 * n : 2;
`ifdef LOADER_CHECKSUM_EN
      if (ok) begin
         x = 8'h00;
         for (int i = 0; i < 2 + 4 * n; i++) x ^= stream[i];
         ok = (stream[2 + 4 * n] === x);
         consumed++;
      end
`endif
      wq.delete();
      pulse_start();
      chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
      for (int i = 0; i < consumed; i++) send_byte(stream[i], gaps, poke);
      wait_idle(tag);
      chk({tag, "_nwrites"}, 64'(wq.size()), 64'(nwr));
      for (int i = 0; i < nwr && i < wq.size(); i++) begin
         w = {stream[2 + 4 * i], stream[3 + 4 * i], stream[4 + 4 * i], stream[5 + 4 * i]};
         chk($sformatf("%s_w%0d", tag, i), 64'(wq[i]), 64'({ADDR_W'(i), w}));
      end
      chk({tag, "_done"},     64'(done),     64'(ok));
      chk({tag, "_err"},      64'(err),      64'(!ok));
      chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!ok));
      chk({tag, "_busy"},     64'(busy),     64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("rst0");
      rst = 1'b1;
      @(negedge clk);

      // Two fixed words.
      stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      finish_stream(1'b0);
      run_load("fixed2", 1'b0, 1'b0);
      chk("fixed2_word0", 64'(wq[0]), 64'({10'd0, 32'hDEADBEEF}));
      chk("fixed2_word1", 64'(wq[1]), 64'({10'd1, 32'h01234567}));

      // Zero-length image.
      stream = '{8'h00, 8'h00};
      finish_stream(1'b0);
      run_load("len0", 1'b0, 1'b0);

      // Oversized image: error, and further bytes are refused.
      stream = '{8'h04, 8'h01};
      run_load("toolong", 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (4) begin
         @(negedge clk);
         chk("toolong_refuse", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      chk("toolong_nowrite", 64'(wq.size()), 64'd0);

      // Length exactly DEPTH is legal (lengths just probed at the boundary).
      stream = '{8'h04, 8'h00};
      // Only the header is exercised here; the load is abandoned via reset.
      wq.delete();
      pulse_start();
      send_byte(stream[0], 1'b0, 1'b0);
      send_byte(stream[1], 1'b0, 1'b0);
      chk("depth_ok_err", 64'(err), 64'd0);
      chk("depth_ok_ready", 64'(in_ready), 64'd1);
      #2 rst = 1'b0;
      #1 check_reset_vals("depth_abort");
      @(negedge clk);
      rst = 1'b1;

      // Bursty stream with stray start pulses while busy.
      build_random(3);
      run_load("gappy3", 1'b1, 1'b1);

      for (int t = 0; t < 5; t++) begin
         build_random($urandom_range(1, 6));
         run_load($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 1'b1);
      end

      // Asynchronous reset after 6 data bytes of a 2-word load.
      build_random(2);
      wq.delete();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1 check_reset_vals("midreset");
      chk("midreset_nwrites", 64'(wq.size()), 64'd1);
      chk("midreset_word0", 64'(wq[0]),
          64'({10'd0, stream[2], stream[3], stream[4], stream[5]}));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      build_random(2);
      run_load("after_reset", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      finish_stream(1'b0);
      run_load("cks_good", 1'b0, 1'b0);
      stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      finish_stream(1'b1);
      run_load("cks_bad", 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
